// File: rtl/mac_accumulate_stage_if.sv
// Handshake bundle between the multiplier, the accumulate stage and the
// result writeback path. The DUT side uses the slave modport; the producer/consumer
// side uses the master modport.
//
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clk edge where valid && ready. The sender holds its payload stable while
// valid=1 and ready=0. Valid never depends combinationally on ready.
interface mac_accumulate_stage_if #(
    parameter int MAC_MULT_WIDTH = 16,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_CNT_WIDTH  = 16
);
    // product channel (multiplier -> stage)
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic [MAC_MULT_WIDTH-1:0] in_prod;
    logic                      in_first;
    logic                      in_last;

    // result channel (stage -> writeback)
    logic                      out_valid;
    logic                      out_ready;
    logic [MAC_ACC_WIDTH-1:0]  out_acc;
    logic [MAC_CNT_WIDTH-1:0]  out_count;
    logic                      out_ovf;

    modport master (
        output in_valid, in_sign, in_prod, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_sign, in_prod, in_first, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/mac_accumulate_stage.sv
// mac_accumulate_stage: accumulates a framed stream of multiplier products
// into a wide sum and presents the dot-product result, its beat count and a
// sticky overflow flag on a result handshake.
//
// Optional feature: define MAC_ACC_SAT_EN to clamp the stored sum on any beat
// that overflows (signed: to max/min positive/negative value, unsigned: to
// all-ones). Without it the sum wraps modulo 2^MAC_ACC_WIDTH.
//
// dbg_state encoding: 0 = IDLE, 1 = ACCUM, 2 = DONE.
module mac_accumulate_stage #(
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mac_accumulate_stage_if.slave       bus,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     state;
    logic [MAC_ACC_WIDTH-1:0]   acc_q;
    logic [MAC_CNT_WIDTH-1:0]   cnt_q;
    logic                       ovf_q;

    logic                       accept;
    logic                       restart;
    logic [MAC_ACC_WIDTH-1:0]   base;
    logic [MAC_ACC_WIDTH-1:0]   ext;
    logic [MAC_ACC_WIDTH-1:0]   sum;
    logic                       carry;
    logic                       signed_ovf;
    logic                       beat_ovf;
    logic [MAC_ACC_WIDTH-1:0]   sum_store;
    logic [MAC_CNT_WIDTH-1:0]   cnt_next;
    logic                       ovf_next;

    // Input is stalled only while a finished result is waiting to be taken.
    assign bus.in_ready = (state != S_DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign dbg_state    = state;

    // A new accumulation starts from zero on a first marker or from IDLE.
    assign restart = bus.in_first || (state == S_IDLE);
    assign base    = restart ? '0 : acc_q;

    // Per-beat extension of the product into the accumulator width.
    assign ext = bus.in_sign ? MAC_ACC_WIDTH'($signed(bus.in_prod))
                             : MAC_ACC_WIDTH'(bus.in_prod);

    // Wide add with carry-out for unsigned overflow detection.
    assign {carry, sum} = {1'b0, base} + {1'b0, ext};

    // Signed overflow: operands agree in sign but the result does not.
    assign signed_ovf = (base[MAC_ACC_WIDTH-1] == ext[MAC_ACC_WIDTH-1]) &&
                        (sum[MAC_ACC_WIDTH-1] != base[MAC_ACC_WIDTH-1]);
    assign beat_ovf   = bus.in_sign ? signed_ovf : carry;

    assign ovf_next = (restart ? 1'b0 : ovf_q) | beat_ovf;
    assign cnt_next = restart ? MAC_CNT_WIDTH'(1)
                              : ((&cnt_q) ? cnt_q : cnt_q + MAC_CNT_WIDTH'(1));

`ifdef MAC_ACC_SAT_EN
    // Clamp the stored sum to the extreme value in the overflow direction.
    always_comb begin
        sum_store = sum;
        if (beat_ovf) begin
            if (!bus.in_sign) begin
                sum_store = '1;
            end else if (!base[MAC_ACC_WIDTH-1]) begin
                sum_store = {1'b0, {(MAC_ACC_WIDTH-1){1'b1}}};
            end else begin
                sum_store = {1'b1, {(MAC_ACC_WIDTH-1){1'b0}}};
            end
        end
    end
`else
    assign sum_store = sum;
`endif

    // Control FSM plus accumulator and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_acc   <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc_q <= sum_store;
                        cnt_q <= cnt_next;
                        ovf_q <= ovf_next;
                        if (bus.in_last) begin
                            state         <= S_DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_acc   <= sum_store;
                            bus.out_count <= cnt_next;
                            bus.out_ovf   <= ovf_next;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state         <= S_IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
